hdc_feature_framer: RTL and testbench
=====================================

Name: hdc_feature_framer

Overview:
- Input-side front end for hdc_sensor_fusion.
- Accepts one channel sample per beat on a valid/ready stream from the sensor acquisition path and packs NUM_CHANNEL samples into one full feature frame.
- Presents completed frames on the features_top/fin_valid/fin_ready interface of the fusion core. Acts as the transmitter on that handshake.
- Holds frames in a two-slot ping-pong buffer, so a new frame can fill while the core holds the previous one. Checks frame alignment against an end-of-frame marker.

Parameters:
- NUM_CHANNEL, default `TOTAL_NUM_CHANNEL: samples per frame; must be >= 2.
- CHANNEL_WIDTH, default `CHANNEL_WIDTH: bits per sample.
- ERR_CNT_WIDTH, default 8: width of the saturating alignment-error counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- sin_data  in  CHANNEL_WIDTH  channel sample, channel order 0..NUM_CHANNEL-1.
- sin_last  in  1  asserted with the final sample of a frame.
- sin_valid  in  1  sample valid.
- sin_ready  out  1  framer can accept the sample.
- features_top  out  NUM_CHANNEL*CHANNEL_WIDTH  frame; channel k at bits [k*CHANNEL_WIDTH +: CHANNEL_WIDTH].
- fin_valid  out  1  frame available to the core.
- fin_ready  in  1  core accepts the frame.
- frame_err_cnt  out  ERR_CNT_WIDTH  count of discarded misaligned frames.

Behaviour:
- Reset (rst=0, asynchronous):
  - idx=0, wr_ptr=0, rd_ptr=0, count=0.
  - Both slot buffers cleared to 0.
  - sin_ready=0 while asserted. fin_valid=0, features_top=0, frame_err_cnt=0.
  - A partially filled frame is discarded. Buffered frames are lost.
- Internal state:
  - idx, the fill index 0..NUM_CHANNEL-1.
  - wr_ptr and rd_ptr, 1-bit slot pointers.
  - count, the number of completed frames held, 0..2.
- sin_ready = (count != 2), registered-state only; no combinational path from fin_ready.
- Beat acceptance (sin_valid & sin_ready) writes sin_data into slot[wr_ptr] at channel idx.
- Frame commit:
  - Condition: beat accepted with idx == NUM_CHANNEL-1 and sin_last=1.
  - Effects: wr_ptr toggles, idx=0, count increments.
  - The frame is visible on features_top with fin_valid=1 on the cycle after the final beat is accepted (1-cycle latency).
- Early-last error:
  - Condition: beat accepted with sin_last=1 and idx < NUM_CHANNEL-1.
  - Effects: the partial frame is discarded, idx=0, frame_err_cnt increments. No commit; wr_ptr unchanged.
- Missing-last error:
  - Condition: beat accepted with idx == NUM_CHANNEL-1 and sin_last=0.
  - Effects: same as early-last error (discard, idx=0, frame_err_cnt increments, no commit).
- frame_err_cnt saturates at 2^ERR_CNT_WIDTH-1 and never wraps.
- Output side:
  - fin_valid = (count != 0).
  - features_top = slot[rd_ptr].
  - Pop on fin_valid & fin_ready: rd_ptr toggles, count decrements.
  - features_top and fin_valid are stable while fin_valid=1 and fin_ready=0.
- Simultaneous commit and pop: count unchanged; both pointers toggle.
- Full condition:
  - count==2 forces sin_ready=0.
  - After a pop, sin_ready rises on the next cycle.
  - The slot being filled is never the slot being presented, because count<2 holds whenever filling.
- fin_ready asserted while fin_valid=0 has no effect.
- Sustained throughput: one sample per cycle. Frames back to back with no bubble while count<2.

Test Plan (NUM_CHANNEL=4, CHANNEL_WIDTH=2 unless noted):
- Reset, then stream samples 1,2,3,0 with sin_last on the 4th beat, fin_ready=0 -> features_top=8'b00_11_10_01 and fin_valid=1 exactly 1 cycle after the 4th beat. Output stays held until fin_ready=1, then fin_valid=0 on the next cycle.
- Three back-to-back frames A,B,C with fin_ready=0 -> sin_ready drops after B commits and C's first beat stalls. Pulse fin_ready: A pops, sin_ready=1 one cycle later, C completes. Pop order is A,B,C with exact contents.
- Commit and pop in the same cycle with count=1 -> count stays 1, fin_valid stays 1, features_top switches to the new frame the following cycle.
- sin_last on the 2nd beat, then a valid 4-beat frame -> frame_err_cnt=1, only the valid frame is presented. Separately, 4 beats without sin_last -> frame_err_cnt=2, no frame presented.
- ERR_CNT_WIDTH=2 with 5 misaligned frames -> frame_err_cnt=3 after the 3rd error and stays 3.
- Async reset asserted mid-frame (idx=2) with count=1 -> fin_valid=0, sin_ready=0 and frame_err_cnt=0 immediately, without waiting for a clock. After release, a clean frame is presented correctly with no remnant of prior data.
- Random bench, full-size defaults, 20 frames, random sin_valid/fin_ready gaps -> frames received equal frames sent in order, frame_err_cnt=0.

Source files
------------

// File: rtl/hdc_feature_framer.sv
// Packs one channel sample per beat into NUM_CHANNEL-wide feature frames and
// presents them to the fusion core through a two-slot ping-pong buffer.
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 8
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif

module hdc_feature_framer_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         wr_sel,
  input  logic [W-1:0] wr_data,
  input  logic         rd_sel,
  output logic [W-1:0] rd_data
);
  logic [1:0][W-1:0] slot;

  always_ff @(posedge clk or negedge rst)
    if (!rst)       slot <= '0;
    else if (wr_en) slot[wr_sel] <= wr_data;

  assign rd_data = slot[rd_sel];
endmodule

module hdc_feature_framer #(
  parameter int NUM_CHANNEL   = `TOTAL_NUM_CHANNEL,
  parameter int CHANNEL_WIDTH = `CHANNEL_WIDTH,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNEL_WIDTH-1:0]           sin_data,
  input  logic                               sin_last,
  input  logic                               sin_valid,
  output logic                               sin_ready,
  output logic [NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
  output logic                               fin_valid,
  input  logic                               fin_ready,
  output logic [ERR_CNT_WIDTH-1:0]           frame_err_cnt
);
  localparam int IDX_W = $clog2(NUM_CHANNEL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNEL - 1);

  logic [IDX_W-1:0] idx;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             accept, at_end, commit, misalign, pop;
  logic [NUM_CHANNEL-1:0][CHANNEL_WIDTH-1:0] lane_out;

  // Ready depends only on held-frame count; reset forces it low on the pin.
  assign sin_ready = rst && (count != 2'd2);
  assign fin_valid = (count != 2'd0);
  assign accept    = sin_valid && (count != 2'd2);
  assign at_end    = (idx == LAST_IDX);
  assign commit    = accept && at_end && sin_last;
  assign misalign  = accept && (at_end != sin_last);
  assign pop       = fin_valid && fin_ready;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx    <= '0;
      wr_ptr <= 1'b0;
    end else if (accept) begin
      idx <= (at_end || sin_last) ? '0 : idx + IDX_W'(1);
      if (commit) wr_ptr <= ~wr_ptr;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (pop) rd_ptr <= ~rd_ptr;
      case ({commit, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst)
      frame_err_cnt <= '0;
    else if (misalign && (frame_err_cnt != {ERR_CNT_WIDTH{1'b1}}))
      frame_err_cnt <= frame_err_cnt + ERR_CNT_WIDTH'(1);

  // count<2 whenever a beat is accepted, so wr_ptr never aliases the presented slot.
  for (genvar k = 0; k < NUM_CHANNEL; k++) begin : g_lane
    hdc_feature_framer_lane #(.W(CHANNEL_WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept && (idx == IDX_W'(k))),
      .wr_sel  (wr_ptr),
      .wr_data (sin_data),
      .rd_sel  (rd_ptr),
      .rd_data (lane_out[k])
    );
  end

  assign features_top = lane_out;
endmodule

// File: tb/tb_hdc_feature_framer.sv
// Bench: small instance checked cycle-by-cycle against a queue model, plus a
// full-size instance fed random frames and checked with an in-order scoreboard.
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 8
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 8
`endif

module tb_hdc_feature_framer;
  localparam int FNC = `TOTAL_NUM_CHANNEL;
  localparam int FCW = `CHANNEL_WIDTH;
  localparam int FW  = FNC * FCW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] s_sin_data = '0;
  logic       s_sin_last = 1'b0, s_sin_valid = 1'b0, s_fin_ready = 1'b0;
  logic       s_sin_ready, s_fin_valid;
  logic [7:0] s_feat;
  logic [1:0] s_err;

  logic [FCW-1:0] f_sin_data = '0;
  logic           f_sin_last = 1'b0, f_sin_valid = 1'b0, f_fin_ready;
  logic           f_sin_ready, f_fin_valid;
  logic [FW-1:0]  f_feat;
  logic [7:0]     f_err;

  hdc_feature_framer #(.NUM_CHANNEL(4), .CHANNEL_WIDTH(2), .ERR_CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .sin_data(s_sin_data), .sin_last(s_sin_last),
    .sin_valid(s_sin_valid), .sin_ready(s_sin_ready), .features_top(s_feat),
    .fin_valid(s_fin_valid), .fin_ready(s_fin_ready), .frame_err_cnt(s_err));

  hdc_feature_framer dut_f (
    .clk(clk), .rst(rst), .sin_data(f_sin_data), .sin_last(f_sin_last),
    .sin_valid(f_sin_valid), .sin_ready(f_sin_ready), .features_top(f_feat),
    .fin_valid(f_fin_valid), .fin_ready(f_fin_ready), .frame_err_cnt(f_err));

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: handshake timed out", name);
  endtask

  // Behavioural model of the small instance: a FIFO of completed frames (depth 2),
  // the partial frame being assembled and a saturating error count.
  logic [7:0] mq[$];
  logic [1:0] mpart[4];
  int  midx = 0, merr = 0;
  bit  macc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      midx = 0;
      merr = 0;
    end else begin
      macc = s_sin_valid && (mq.size() < 2);
      if (mq.size() != 0 && s_fin_ready) void'(mq.pop_front());
      if (macc) begin
        mpart[midx] = s_sin_data;
        if (s_sin_last && midx == 3) begin
          mq.push_back({mpart[3], mpart[2], mpart[1], mpart[0]});
          midx = 0;
        end else if (s_sin_last || midx == 3) begin
          if (merr < 3) merr++;
          midx = 0;
        end else midx++;
      end
    end
  end

  always @(negedge clk) begin
    check("s_sin_ready", s_sin_ready, rst && (mq.size() < 2));
    check("s_fin_valid", s_fin_valid, mq.size() != 0);
    if (mq.size() != 0) check("s_features", s_feat, mq[0]);
    check("s_err_cnt", s_err, merr);
  end

  // Full-size scoreboard: frames must pop in the order they were sent.
  logic [FW-1:0] sent_q[$];
  logic [FW-1:0] f_fr;
  int  rx = 0;
  bit  f_rand_on = 1'b0;

  always @(negedge clk) begin
    if (rst && f_fin_valid && f_fin_ready) begin
      if (sent_q.size() == 0) fail_now("f_unexpected_frame");
      else check("f_frame", f_feat, sent_q.pop_front());
      rx++;
    end
  end

  always begin
    @(posedge clk);
    #1;
    f_fin_ready = f_rand_on && ($urandom_range(0, 2) != 0);
  end

  task automatic send_s(input logic [1:0] d, input logic l);
    bit ok = 1'b0;
    s_sin_valid = 1'b1; s_sin_data = d; s_sin_last = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = s_sin_ready;
      @(posedge clk); #1;
    end
    if (!ok) fail_now("s_send");
    s_sin_valid = 1'b0; s_sin_last = 1'b0;
  endtask

  task automatic send_frame_s(input logic [7:0] fr);
    for (int k = 0; k < 4; k++) send_s(fr[2*k +: 2], k == 3);
  endtask

  task automatic expect_pop_s(input string name, input logic [7:0] fr);
    check({name, "_valid"}, s_fin_valid, 1);
    check({name, "_data"}, s_feat, fr);
    s_fin_ready = 1'b1;
    @(posedge clk); #1;
    s_fin_ready = 1'b0;
  endtask

  task automatic send_f(input logic [FCW-1:0] d, input logic l);
    bit ok = 1'b0;
    f_sin_valid = 1'b1; f_sin_data = d; f_sin_last = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); ok = f_sin_ready;
      @(posedge clk); #1;
    end
    if (!ok) fail_now("f_send");
    f_sin_valid = 1'b0; f_sin_last = 1'b0;
  endtask

  logic [7:0] fa, fb, fc, fe;
  int  sk;
  bit  sr;

  initial begin
    rst = 1'b0;
    #1;
    check("rst_s_ready", s_sin_ready, 0);
    check("rst_s_valid", s_fin_valid, 0);
    check("rst_s_feat", s_feat, 0);
    check("rst_s_err", s_err, 0);
    check("rst_f_ready", f_sin_ready, 0);
    check("rst_f_valid", f_fin_valid, 0);
    #21 rst = 1'b1;
    @(posedge clk); #1;

    // Samples 1,2,3,0 -> 8'b00_11_10_01, held while fin_ready is low.
    send_frame_s(8'h39);
    check("t1_valid_next", s_fin_valid, 1);
    check("t1_feat_next", s_feat, 8'h39);
    repeat (3) begin @(posedge clk); #1; end
    expect_pop_s("t1_pop", 8'h39);
    check("t1_empty", s_fin_valid, 0);

    // Back-to-back A,B,C: C stalls until A pops.
    fa = 8'h1B; fb = 8'h2D; fc = 8'hC6;
    send_frame_s(fa);
    send_frame_s(fb);
    check("t2_full", s_sin_ready, 0);
    fork
      send_frame_s(fc);
      begin
        repeat (2) @(posedge clk);
        #1;
        check("t2_stall", s_sin_ready, 0);
        expect_pop_s("t2_A", fa);
        check("t2_ready_back", s_sin_ready, 1);
      end
    join
    expect_pop_s("t2_B", fb);
    expect_pop_s("t2_C", fc);
    check("t2_empty", s_fin_valid, 0);

    // Commit and pop on the same edge with one frame held.
    send_frame_s(8'h5A);
    fe = 8'hE4;
    for (int k = 0; k < 3; k++) send_s(fe[2*k +: 2], 1'b0);
    s_sin_valid = 1'b1; s_sin_data = fe[7:6]; s_sin_last = 1'b1; s_fin_ready = 1'b1;
    @(posedge clk); #1;
    s_sin_valid = 1'b0; s_sin_last = 1'b0; s_fin_ready = 1'b0;
    check("t3_valid", s_fin_valid, 1);
    check("t3_switch", s_feat, fe);
    expect_pop_s("t3_E", fe);
    check("t3_empty", s_fin_valid, 0);

    // Early last, then a good frame; then a frame missing its last.
    send_s(2'd1, 1'b0);
    send_s(2'd2, 1'b1);
    check("t4_err1", s_err, 1);
    send_frame_s(8'h93);
    expect_pop_s("t4_good", 8'h93);
    check("t4_only_good", s_fin_valid, 0);
    for (int k = 0; k < 4; k++) send_s(2'(k), 1'b0);
    check("t4_err2", s_err, 2);
    check("t4_no_frame", s_fin_valid, 0);

    // Three more misaligned frames: counter pins at 3.
    for (int n = 0; n < 3; n++) begin
      send_s(2'd0, 1'b0);
      send_s(2'd3, 1'b1);
      if (n == 0) check("t5_err3", s_err, 3);
    end
    check("t5_sat", s_err, 3);

    // Asynchronous reset mid-frame with a frame held.
    send_frame_s(8'h6C);
    send_s(2'd1, 1'b0);
    send_s(2'd2, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t6_valid", s_fin_valid, 0);
    check("t6_ready", s_sin_ready, 0);
    check("t6_err", s_err, 0);
    check("t6_feat", s_feat, 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;
    send_frame_s(8'hB1);
    expect_pop_s("t6_clean", 8'hB1);
    check("t6_empty", s_fin_valid, 0);

    // Random traffic on the small instance, mostly well-framed.
    sk = 0;
    repeat (300) begin
      s_sin_valid = ($urandom_range(0, 3) != 0);
      s_sin_data  = 2'($urandom);
      s_sin_last  = (sk == 3) ^ ($urandom_range(0, 15) == 0);
      s_fin_ready = $urandom_range(0, 1);
      @(negedge clk); sr = s_sin_ready;
      @(posedge clk); #1;
      if (s_sin_valid && sr) sk = (s_sin_last || sk == 3) ? 0 : sk + 1;
    end
    s_sin_valid = 1'b0; s_sin_last = 1'b0; s_fin_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    s_fin_ready = 1'b0;

    // Full-size random frames with random gaps on both sides.
    f_rand_on = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < FNC; k++) f_fr[k*FCW +: FCW] = FCW'($urandom);
      sent_q.push_back(f_fr);
      for (int k = 0; k < FNC; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_f(f_fr[k*FCW +: FCW], k == FNC - 1);
      end
    end
    for (int i = 0; i < 2000 && rx < 20; i++) @(posedge clk);
    #1;
    f_rand_on = 1'b0;
    check("f_rx_count", rx, 20);
    check("f_err_cnt", f_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
